// File: rtl/maddadd_result_axis.sv
// mAddAdd QTree result stage: times a run, captures the tagged result,
// and reports status/latency and value as a two-beat AXI-Stream packet.
module maddadd_result_axis #(
   parameter int          CNT_W   = 32,
   parameter int unsigned TIMEOUT = 65536
) (
   input  logic        clk,
   input  logic        aresetn,
   input  logic        in_tvalid,
   input  logic        in_tready,
   input  logic [31:0] result_data,
   output logic        result_ready,
   output logic [63:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        busy,
   output logic        done,
   input  logic        clear
);

   typedef enum logic [2:0] {
      IDLE, RUN, SEND0, SEND1, DONE
   } state_t;

   localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt, cnt_inc, lat;
   logic [30:0]        val;
   logic [7:0]         status;
   logic [31:0]        lat32;
   logic               rv_q, res_edge, start;
   logic               cap_res, cap_to;

   assign start    = in_tvalid & in_tready;
   assign res_edge = result_data[0] & ~rv_q;
   assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;

   generate
      if (CNT_W >= 32) begin : g_lat_trunc
         assign lat32 = lat[31:0];
      end else begin : g_lat_ext
         assign lat32 = {{(32-CNT_W){1'b0}}, lat};
      end
   endgenerate

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      cap_res = 1'b0;
      cap_to  = 1'b0;
      unique case (state_q)
         IDLE:  if (start) state_d = RUN;
         RUN: begin
            if (res_edge) begin
               cap_res = 1'b1;
               state_d = SEND0;
            end else if (cnt_inc == TO) begin
               cap_to  = 1'b1;
               state_d = SEND0;
            end
         end
         SEND0: if (m_axis_tready) state_d = SEND1;
         SEND1: if (m_axis_tready) state_d = DONE;
         DONE:  if (clear) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         cnt    <= '0;
         rv_q   <= 1'b0;
         lat    <= '0;
         val    <= '0;
         status <= '0;
      end else begin
         rv_q <= result_data[0];
         if (state_q == IDLE && start) begin
            cnt <= '0;
         end else if (state_q == RUN && !cap_res && !cap_to) begin
            cnt <= cnt_inc;
         end
         if (cap_res) begin
            val    <= result_data[31:1];
            lat    <= cnt_inc;
            status <= 8'h01;
         end else if (cap_to) begin
            val    <= '0;
            lat    <= TO;
            status <= 8'h02;
         end
      end
   end

   // Outputs decode registered state only, so they drop with reset.
   assign result_ready  = (state_q == RUN);
   assign m_axis_tvalid = (state_q == SEND0) | (state_q == SEND1);
   assign m_axis_tlast  = (state_q == SEND1);
   assign busy          = (state_q == RUN) | m_axis_tvalid;
   assign done          = (state_q == DONE);

   always_comb begin
      m_axis_tdata = '0;
      if (state_q == SEND0) m_axis_tdata = {status, 24'd0, lat32};
      else if (state_q == SEND1) m_axis_tdata = {33'd0, val};
   end

endmodule

// File: tb/tb_maddadd_result_axis.sv
// Directed bench for maddadd_result_axis with TIMEOUT=16.
// Expected beats are hand-computed from the run timing.
module tb_maddadd_result_axis;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic        in_tvalid = 1'b0;
   logic        in_tready = 1'b0;
   logic [31:0] result_data = '0;
   logic        result_ready;
   logic [63:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        m_axis_tlast;
   logic        busy;
   logic        done;
   logic        clear = 1'b0;

   int checks = 0;
   int errors = 0;
   int hs = 0;
   int h0;

   maddadd_result_axis #(.CNT_W(32), .TIMEOUT(16)) dut (
      .clk(clk),
      .aresetn(aresetn),
      .in_tvalid(in_tvalid),
      .in_tready(in_tready),
      .result_data(result_data),
      .result_ready(result_ready),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast),
      .busy(busy),
      .done(done),
      .clear(clear)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (aresetn && m_axis_tvalid && m_axis_tready) hs++;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_run();
      in_tvalid = 1'b1;
      in_tready = 1'b1;
      step();
      in_tvalid = 1'b0;
      in_tready = 1'b0;
   endtask

   task automatic result_at(input int k, input logic [30:0] v);
      step(k - 1);
      chk("ready_pre", 64'(result_ready), 64'd1);
      result_data = {v, 1'b1};
      step();
      chk("ready_post", 64'(result_ready), 64'd0);
   endtask

   task automatic drain(input string tag, input logic [63:0] b0,
                        input logic [63:0] b1);
      m_axis_tready = 1'b1;
      chk({tag, "_v0"}, 64'(m_axis_tvalid), 64'd1);
      chk({tag, "_b0"}, m_axis_tdata, b0);
      chk({tag, "_l0"}, 64'(m_axis_tlast), 64'd0);
      step();
      chk({tag, "_b1"}, m_axis_tdata, b1);
      chk({tag, "_l1"}, 64'(m_axis_tlast), 64'd1);
      step();
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_vend"}, 64'(m_axis_tvalid), 64'd0);
      m_axis_tready = 1'b0;
   endtask

   task automatic clear_run();
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_done", 64'(done), 64'd0);
      result_data = '0;
      step();
   endtask

   initial begin
      step(2);
      chk("rst_ready", 64'(result_ready), 64'd0);
      chk("rst_valid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_data", m_axis_tdata, 64'd0);
      chk("rst_last", 64'(m_axis_tlast), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      aresetn = 1'b1;
      step(8);

      // normal run, lat 15
      start_run();
      chk("run_busy", 64'(busy), 64'd1);
      result_at(15, 31'd1234);
      drain("norm", 64'h0100_0000_0000_000F, 64'd1234);

      // backpressure on both beats
      clear_run();
      start_run();
      result_at(15, 31'd1234);
      h0 = hs;
      for (int i = 0; i < 5; i++) begin
         chk("bp_v0", 64'(m_axis_tvalid), 64'd1);
         chk("bp_b0", m_axis_tdata, 64'h0100_0000_0000_000F);
         chk("bp_l0", 64'(m_axis_tlast), 64'd0);
         step();
      end
      m_axis_tready = 1'b1;
      step();
      m_axis_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_v1", 64'(m_axis_tvalid), 64'd1);
         chk("bp_b1", m_axis_tdata, 64'd1234);
         chk("bp_l1", 64'(m_axis_tlast), 64'd1);
         step();
      end
      m_axis_tready = 1'b1;
      step();
      m_axis_tready = 1'b0;
      chk("bp_done", 64'(done), 64'd1);
      chk("bp_hs", 64'(hs - h0), 64'd2);

      // timeout after 16 run cycles
      clear_run();
      start_run();
      step(15);
      chk("to_ready15", 64'(result_ready), 64'd1);
      step();
      chk("to_ready16", 64'(result_ready), 64'd0);
      drain("to", 64'h0200_0000_0000_0010, 64'd0);

      // result on the timeout edge wins
      clear_run();
      start_run();
      result_at(16, 31'h4321);
      drain("sim", 64'h0100_0000_0000_0010, 64'h4321);

      // clear with stale result high re-arms into a timeout
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("rearm_done", 64'(done), 64'd0);
      start_run();
      step(15);
      chk("rearm_ready", 64'(result_ready), 64'd1);
      step();
      drain("rearm", 64'h0200_0000_0000_0010, 64'd0);

      // async reset while beat 0 is stalled
      clear_run();
      start_run();
      result_at(5, 31'd99);
      step(2);
      chk("mr_v0", 64'(m_axis_tvalid), 64'd1);
      #2 aresetn = 1'b0;
      #1;
      chk("mr_valid", 64'(m_axis_tvalid), 64'd0);
      chk("mr_busy", 64'(busy), 64'd0);
      chk("mr_done", 64'(done), 64'd0);
      result_data = '0;
      step();
      aresetn = 1'b1;
      step();
      chk("mr_idle", 64'(busy), 64'd0);
      start_run();
      result_at(7, 31'd77);
      drain("mr", 64'h0100_0000_0000_0007, 64'd77);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
